// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and default SCK half-period.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_WAIT,
        S_HOLD,
        S_GAP
    } spi_state_t;

    localparam int CLK_DIV_DEFAULT = 8;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module spi_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, one byte per start/ready handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | SSEL high, accepting a byte to open a transaction
// SETUP | SSEL low, first MOSI bit presented, waiting before 1st rise
// LOW   | SCK low half-period, MOSI holds the next bit
// HIGH  | SCK high half-period, MISO sampled in its final cycle
// WAIT  | byte done, SSEL held low, accepting the next byte
// HOLD  | trailing SCK-low half-period plus SSEL hold before release
// GAP   | SSEL high, minimum deselect time before IDLE
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       last,
    output logic       ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SCK,
    output logic       SSEL,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [8:0] HALF     = 9'(CLK_DIV - 1);
    // HOLD keeps SCK low for one full half-period after the 8th fall and
    // then holds SSEL low for another half-period before releasing it.
    localparam logic [8:0] HOLD_LEN = 9'(2 * CLK_DIV - 1);

    spi_state_t state, state_n;
    logic [8:0] cnt, cnt_n;
    logic [2:0] bit_cnt;
    logic [6:0] tx_sh;
    logic [6:0] rx_sh;
    logic       last_q;
    logic       miso_s;
    logic       accept;
    logic       leave_high;
    logic       tc;

    spi_sync2 u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (MISO),
        .q     (miso_s)
    );

    // State register and phase down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; every timed phase ends on counter terminal count.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        accept     = 1'b0;
        leave_high = 1'b0;
        tc         = (cnt == 9'd0);
        case (state)
            S_IDLE, S_WAIT: begin
                if (start && ready) begin
                    accept  = 1'b1;
                    state_n = (state == S_IDLE) ? S_SETUP : S_LOW;
                    cnt_n   = HALF;
                end
            end
            S_SETUP, S_LOW: begin
                if (tc) begin
                    state_n = S_HIGH;
                    cnt_n   = HALF;
                end else begin
                    cnt_n = cnt - 9'd1;
                end
            end
            S_HIGH: begin
                if (tc) begin
                    leave_high = 1'b1;
                    cnt_n      = HALF;
                    if (bit_cnt != 3'd7) begin
                        state_n = S_LOW;
                    end else if (last_q) begin
                        state_n = S_HOLD;
                        cnt_n   = HOLD_LEN;
                    end else begin
                        state_n = S_WAIT;
                    end
                end else begin
                    cnt_n = cnt - 9'd1;
                end
            end
            S_HOLD: begin
                if (tc) begin
                    state_n = S_GAP;
                    cnt_n   = HALF;
                end else begin
                    cnt_n = cnt - 9'd1;
                end
            end
            S_GAP: begin
                if (tc) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 9'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Shift datapath and registered pin/handshake outputs decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last_q   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            MOSI     <= 1'b0;
            SCK      <= 1'b0;
            SSEL     <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                MOSI   <= tx_data[7];
                tx_sh  <= tx_data[6:0];
                last_q <= last;
            end
            if (leave_high) begin
                rx_sh   <= {rx_sh[5:0], miso_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_sh, miso_s};
                    rx_valid <= 1'b1;
                end else begin
                    MOSI  <= tx_sh[6];
                    tx_sh <= {tx_sh[5:0], 1'b0};
                end
            end
            SCK   <= (state_n == S_HIGH);
            SSEL  <= (state_n == S_IDLE) || (state_n == S_GAP);
            ready <= (state_n == S_IDLE) || (state_n == S_WAIT);
            busy  <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: bus-level model on every cycle plus directed scenarios.
module tb_spi_master;

    localparam int D   = 8;
    localparam int LIM = 3000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       last     = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       miso_tie = 1'b0;
    logic       ready, rx_valid, busy, sck, ssel, mosi, miso;
    logic [7:0] rx_data;

    assign miso = miso_tie ? 1'b1 : mosi;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tx_data  (tx_data),
        .last     (last),
        .ready    (ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .SCK      (sck),
        .SSEL     (ssel),
        .MOSI     (mosi),
        .MISO     (miso)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Bus-level model: bytes expected on MOSI and on rx_data, in order.
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int         rises = 0, rxv_cnt = 0, ssel_rises = 0, edge_in_byte = 0, cyc = 0;
    int         last_rise_cyc = 0, ssel_low = 0, last_ssel_len = 0, exp_ssel_len = 0;
    int         ssel_rise_cyc = 0, gap_len = 0, last_period = 0;
    logic [7:0] last_rx = 8'h00;
    logic       p_sck = 1'b0, p_mosi = 1'b0, p_ssel = 1'b1, p_rxv = 1'b0, p_busy = 1'b0;

    // Compare process: checks bus invariants and model expectations every cycle.
    always @(negedge clk) begin
        logic [7:0] cur;
        cyc++;
        if (!rst_n) begin
            exp_tx.delete();
            exp_rx.delete();
            edge_in_byte = 0;
            ssel_low     = 0;
        end else begin
            if (sck && p_sck) check("mosi_stable_while_sck_high", mosi, p_mosi);
            if (ssel) check("sck_low_while_deselected", sck, 0);
            if (rx_valid) check("rx_valid_single_cycle", p_rxv, 0);
            if (sck && !p_sck) begin
                rises++;
                check("sck_rise_has_pending_byte", int'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) begin
                    cur = exp_tx[0];
                    check("mosi_bit_at_rise", mosi, cur[7 - edge_in_byte]);
                    if (edge_in_byte != 0) begin
                        last_period = cyc - last_rise_cyc;
                        check("sck_period", last_period, 2 * D);
                    end
                    edge_in_byte++;
                    if (edge_in_byte == 8) begin
                        exp_rx.push_back(miso_tie ? 8'hFF : cur);
                        void'(exp_tx.pop_front());
                        edge_in_byte = 0;
                    end
                end
                last_rise_cyc = cyc;
            end
            if (rx_valid) begin
                rxv_cnt++;
                last_rx = rx_data;
                check("rx_valid_has_expected_byte", exp_rx.size(), 1);
                if (exp_rx.size() > 0) begin
                    check("rx_data", rx_data, exp_rx[0]);
                    void'(exp_rx.pop_front());
                end
            end
            if (!ssel) ssel_low++;
            if (ssel && !p_ssel) begin
                last_ssel_len = ssel_low;
                ssel_low      = 0;
                ssel_rises++;
                ssel_rise_cyc = cyc;
                if (exp_ssel_len != 0) check("ssel_low_cycles", last_ssel_len, exp_ssel_len);
            end
            if (!busy && p_busy) gap_len = cyc - ssel_rise_cyc;
        end
        p_sck  = sck;
        p_mosi = mosi;
        p_ssel = ssel;
        p_rxv  = rx_valid;
        p_busy = busy;
    end

    task automatic send(input logic [7:0] b, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait_bounded", int'(t < LIM), 1);
        start   = 1'b1;
        tx_data = b;
        last    = l;
        exp_tx.push_back(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait_bounded", int'(t < LIM), 1);
        repeat (3) @(negedge clk);
    endtask

    int r0, v0, s0, t;

    initial begin
        #12;
        check("reset_sck", sck, 0);
        check("reset_ssel", ssel, 1);
        check("reset_mosi", mosi, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", ready, 1);
        check("post_reset_busy", busy, 0);

        // Loopback single byte 0xA5.
        r0 = rises; v0 = rxv_cnt;
        exp_ssel_len = 18 * D;
        send(8'hA5, 1'b1);
        wait_idle();
        check("a5_rises", rises - r0, 8);
        check("a5_rx_pulses", rxv_cnt - v0, 1);
        check("a5_last_rx", last_rx, 8'hA5);
        check("a5_rx_data_held", rx_data, 8'hA5);
        check("a5_ssel_len", last_ssel_len, 144);
        check("a5_period", last_period, 16);
        check("a5_gap", gap_len, 8);

        // MISO tied high, send 0x00.
        miso_tie = 1'b1;
        r0 = rises;
        send(8'h00, 1'b1);
        wait_idle();
        check("zero_rises", rises - r0, 8);
        check("zero_rx", last_rx, 8'hFF);
        check("zero_rx_data_held", rx_data, 8'hFF);
        miso_tie = 1'b0;

        // Two-byte transaction; WAIT lasts one cycle with this send timing.
        r0 = rises; v0 = rxv_cnt; s0 = ssel_rises;
        exp_ssel_len = 34 * D + 1;
        send(8'h12, 1'b0);
        send(8'h34, 1'b1);
        wait_idle();
        check("two_rises", rises - r0, 16);
        check("two_rx_pulses", rxv_cnt - v0, 2);
        check("two_ssel_releases", ssel_rises - s0, 1);
        check("two_last_rx", last_rx, 8'h34);
        check("two_ssel_len", last_ssel_len, 273);
        check("two_gap", gap_len, 8);

        // start pulsed during HIGH is ignored.
        r0 = rises; v0 = rxv_cnt;
        exp_ssel_len = 18 * D;
        send(8'h3C, 1'b1);
        t = 0;
        while (!sck && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("sck_high_wait_bounded", int'(t < LIM), 1);
        @(negedge clk);
        start = 1'b1; tx_data = 8'hFF; last = 1'b0;
        check("ready_low_in_high", ready, 0);
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (busy && t < LIM) begin
            check("ready_low_while_busy", ready, 0);
            @(negedge clk);
            t++;
        end
        check("ignore_wait_bounded", int'(t < LIM), 1);
        repeat (3) @(negedge clk);
        check("ignore_rises", rises - r0, 8);
        check("ignore_rx_pulses", rxv_cnt - v0, 1);
        check("ignore_last_rx", last_rx, 8'h3C);

        // Reset after the 3rd SCK rise aborts the byte.
        exp_ssel_len = 0;
        r0 = rises; v0 = rxv_cnt;
        send(8'h77, 1'b1);
        t = 0;
        while ((rises - r0) < 3 && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("third_rise_wait_bounded", int'(t < LIM), 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ssel", ssel, 1);
        check("abort_sck", sck, 0);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_rx_pulse", rxv_cnt - v0, 0);
        check("abort_ready", ready, 1);
        r0 = rises; v0 = rxv_cnt;
        exp_ssel_len = 18 * D;
        send(8'h5A, 1'b1);
        wait_idle();
        check("after_reset_rises", rises - r0, 8);
        check("after_reset_rx_pulses", rxv_cnt - v0, 1);
        check("after_reset_rx", last_rx, 8'h5A);
        check("after_reset_ssel_len", last_ssel_len, 144);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
